// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - record/playback note sequencer driving an external note memory
module note_sequencer #(
  parameter int HOLD_TICKS = 12500000,
  parameter int ADDR_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              play,
  input  logic              record,
  input  logic              stop,
  input  logic              loop,
  input  logic              key_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W:0]   note_count,
  output logic              note_enable,
  output logic              recording,
  output logic              playing,
  output logic              finish
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RECORD = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Hold counter runs HOLD_TICKS-1 down to 0, so clog2(HOLD_TICKS) bits suffice.
  localparam int CNT_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [ADDR_W:0]   LAST_SLOT  = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  hold_cnt;
  logic              last_note;

  // The note being held is the last stored one when rd_ptr+1 reaches note_count.
  assign last_note = (({1'b0, rd_ptr} + COUNT_ONE) >= note_count);

  // Status strobes decode straight from the state register so reset clears them at once.
  assign mem_re      = (state == S_FETCH);
  assign note_enable = (state == S_HOLD);
  assign recording   = (state == S_RECORD);
  assign playing     = (state == S_FETCH) || (state == S_HOLD);
  assign finish      = (state == S_DONE);

  // Sequencer state, pointers, note count, hold timer and registered memory controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold_cnt   <= '0;
      note_count <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (record) begin
            state      <= S_RECORD;
            wr_ptr     <= '0;
            note_count <= '0;
          end else if (play && (note_count != '0)) begin
            state    <= S_FETCH;
            rd_ptr   <= '0;
            mem_addr <= '0;
          end
        end
        S_RECORD: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (key_valid) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            wr_ptr     <= wr_ptr + PTR_ONE;
            note_count <= note_count + COUNT_ONE;
            // Memory full after this write: leave so later strobes cannot overwrite.
            if (note_count == LAST_SLOT) state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end else if (!last_note) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            mem_addr <= rd_ptr + PTR_ONE;
            state    <= S_FETCH;
          end else if (loop) begin
            rd_ptr   <= '0;
            mem_addr <= '0;
            state    <= S_FETCH;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;

  localparam int HT = 4;
  localparam int AW = 6;
  localparam int PER = HT + 1;

  logic          clock;
  logic          reset;
  logic          play;
  logic          record;
  logic          stop;
  logic          loop;
  logic          key_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [AW:0]   note_count;
  logic          note_enable;
  logic          recording;
  logic          playing;
  logic          finish;

  int errors;
  int checks;
  int rand_n;

  note_sequencer #(.HOLD_TICKS(HT), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .play        (play),
    .record      (record),
    .stop        (stop),
    .loop        (loop),
    .key_valid   (key_valid),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .note_count  (note_count),
    .note_enable (note_enable),
    .recording   (recording),
    .playing     (playing),
    .finish      (finish)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({mem_addr, mem_we, mem_re, note_count, note_enable, recording, playing, finish} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d we=%0b re=%0b cnt=%0d en=%0b rec=%0b pl=%0b fin=%0b exp all 0",
               mem_addr, mem_we, mem_re, note_count, note_enable, recording, playing, finish);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({recording, playing, finish, note_count} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle got rec=%0b pl=%0b fin=%0b cnt=%0d exp 0", recording, playing, finish, note_count);
    end
  endtask

  task automatic test_empty();
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    checks++;
    if ({mem_we, note_count} !== '0) begin
      errors++;
      $display("FAIL idle_key_valid got we=%0b cnt=%0d exp 0 0", mem_we, note_count);
    end
    play = 1'b1;
    step();
    play = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_re, playing, finish, note_enable} !== 4'b0) begin
        errors++;
        $display("FAIL empty_play c=%0d got re=%0b pl=%0b fin=%0b en=%0b exp 0", c, mem_re, playing, finish, note_enable);
      end
      step();
    end
  endtask

  task automatic do_record(input int n, input int gap);
    int g;
    record = 1'b1;
    step();
    record = 1'b0;
    checks++;
    if (recording !== 1'b1 || note_count !== '0) begin
      errors++;
      $display("FAIL rec_start got rec=%0b cnt=%0d exp 1 0", recording, note_count);
    end
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || note_count !== (AW+1)'(i + 1)) begin
        errors++;
        $display("FAIL rec_write i=%0d got we=%0b addr=%0d cnt=%0d exp 1 %0d %0d", i, mem_we, mem_addr, note_count, i, i + 1);
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        step();
        checks++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL rec_gap i=%0d got we=%0b exp 0", i, mem_we);
        end
      end
    end
    stop = 1'b1;
    key_valid = 1'b1;
    step();
    stop = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (recording !== 1'b0 || mem_we !== 1'b0 || note_count !== (AW+1)'(n)) begin
      errors++;
      $display("FAIL rec_stop got rec=%0b we=%0b cnt=%0d exp 0 0 %0d", recording, mem_we, note_count, n);
    end
  endtask

  task automatic test_play_once(input int n);
    bit exp_re, exp_en, exp_fin, exp_pl;
    loop = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    for (int c = 0; c <= PER * n + 1; c++) begin
      exp_re  = (c < PER * n) && (c % PER == 0);
      exp_en  = (c < PER * n) && (c % PER != 0);
      exp_fin = (c == PER * n);
      exp_pl  = (c < PER * n);
      checks++;
      if ({mem_re, note_enable, finish, playing, mem_we, recording} !== {exp_re, exp_en, exp_fin, exp_pl, 2'b00}) begin
        errors++;
        $display("FAIL play_once c=%0d got re/en/fin/pl/we/rec=%b exp %b", c,
                 {mem_re, note_enable, finish, playing, mem_we, recording}, {exp_re, exp_en, exp_fin, exp_pl, 2'b00});
      end
      if (exp_re) begin
        checks++;
        if (mem_addr !== AW'(c / PER)) begin
          errors++;
          $display("FAIL play_once_addr c=%0d got %0d exp %0d", c, mem_addr, c / PER);
        end
      end
      // loop only matters at hold expiry; wiggle it elsewhere
      loop      = (c % PER == PER - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      record    = (c == 2);
      key_valid = (c == 3);
      step();
    end
    loop = 1'b0;
    record = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (note_count !== (AW+1)'(n) || playing !== 1'b0) begin
      errors++;
      $display("FAIL play_once_end got cnt=%0d pl=%0b exp %0d 0", note_count, playing, n);
    end
  endtask

  task automatic test_play_loop(input int n);
    int last_c;
    bit exp_re;
    last_c = PER * 4 + 2;
    play = 1'b1;
    loop = 1'b1;
    step();
    play = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      exp_re = (c % PER == 0);
      checks++;
      if ({mem_re, note_enable, finish, playing} !== {exp_re, !exp_re, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL play_loop c=%0d got re/en/fin/pl=%b exp %b", c,
                 {mem_re, note_enable, finish, playing}, {exp_re, !exp_re, 1'b0, 1'b1});
      end
      if (exp_re) begin
        checks++;
        if (mem_addr !== AW'((c / PER) % n)) begin
          errors++;
          $display("FAIL play_loop_addr c=%0d got %0d exp %0d", c, mem_addr, (c / PER) % n);
        end
      end
      loop = (c % PER == PER - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c < last_c) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({note_enable, mem_re, playing, finish} !== 4'b0) begin
        errors++;
        $display("FAIL loop_stop c=%0d got en/re/pl/fin=%b exp 0000", c, {note_enable, mem_re, playing, finish});
      end
      step();
    end
  endtask

  task automatic test_priority(input int n);
    stop = 1'b1;
    record = 1'b1;
    play = 1'b1;
    step();
    stop = 1'b0;
    record = 1'b0;
    play = 1'b0;
    checks++;
    if (recording !== 1'b0 || playing !== 1'b0 || mem_re !== 1'b0 || note_count !== (AW+1)'(n)) begin
      errors++;
      $display("FAIL prio_stop got rec=%0b pl=%0b re=%0b cnt=%0d exp 0 0 0 %0d", recording, playing, mem_re, note_count, n);
    end
    record = 1'b1;
    play = 1'b1;
    step();
    record = 1'b0;
    play = 1'b0;
    checks++;
    if (recording !== 1'b1 || playing !== 1'b0 || note_count !== '0) begin
      errors++;
      $display("FAIL prio_record got rec=%0b pl=%0b cnt=%0d exp 1 0 0", recording, playing, note_count);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_full();
    record = 1'b1;
    step();
    record = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      step();
      checks++;
      if (i < 64) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(i) || note_count !== (AW+1)'(i + 1) || recording !== (i < 63)) begin
          errors++;
          $display("FAIL full_write i=%0d got we=%0b addr=%0d cnt=%0d rec=%0b exp 1 %0d %0d %0b",
                   i, mem_we, mem_addr, note_count, recording, i, i + 1, i < 63);
        end
      end else begin
        if (mem_we !== 1'b0 || note_count !== (AW+1)'(64) || recording !== 1'b0) begin
          errors++;
          $display("FAIL full_65th got we=%0b cnt=%0d rec=%0b exp 0 64 0", mem_we, note_count, recording);
        end
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    play = 1'b1;
    step();
    play = 1'b0;
    step();
    step();
    checks++;
    if (note_enable !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_hold got en=%0b exp 1", note_enable);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_re, note_count, note_enable, recording, playing, finish} !== '0) begin
      errors++;
      $display("FAIL areset_immediate got addr=%0d we=%0b re=%0b cnt=%0d en=%0b rec=%0b pl=%0b fin=%0b exp all 0",
               mem_addr, mem_we, mem_re, note_count, note_enable, recording, playing, finish);
    end
    step();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if ({finish, playing, note_enable, note_count} !== '0) begin
        errors++;
        $display("FAIL areset_after c=%0d got fin=%0b pl=%0b en=%0b cnt=%0d exp 0", c, finish, playing, note_enable, note_count);
      end
    end
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    play = 1'b0;
    record = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    key_valid = 1'b0;
    errors = 0;
    checks = 0;
    test_reset();
    test_empty();
    do_record(3, 1);
    test_play_once(3);
    test_play_loop(3);
    test_priority(3);
    rand_n = int'($urandom_range(1, 8));
    do_record(rand_n, -1);
    test_play_once(rand_n);
    test_full();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
